// File: rtl/rx_buf_loader_if.sv
// Register-access port between the Rx buffer loader and regs_writer.
// The loader is the master: it drives the request, and regs_writer returns read data and ACK_Rx.
interface rx_buf_loader_if;
  logic       REQ_Rx;
  logic       RNW_Rx;
  logic [7:0] ADDR_Rx;
  logic [7:0] WR_DATA_Rx;
  logic [7:0] RD_DATA_Rx;
  logic       ACK_Rx;

  modport master (
    output REQ_Rx, RNW_Rx, ADDR_Rx, WR_DATA_Rx,
    input  RD_DATA_Rx, ACK_Rx
  );

  modport slave (
    input  REQ_Rx, RNW_Rx, ADDR_Rx, WR_DATA_Rx,
    output RD_DATA_Rx, ACK_Rx
  );
endinterface

// File: rtl/rx_buf_loader.sv
// Captures one received USB-PD message into a local buffer, then copies the byte count, frame type and
// message bytes into the TCPC register file and raises ALERT Receive-Status.
module rx_buf_loader #(
  parameter int unsigned MAX_BYTES   = 10,
  parameter logic [7:0]  ADDR_ALERT  = 8'h10,
  parameter logic [7:0]  ADDR_RXDET  = 8'h2F,
  parameter logic [7:0]  ADDR_RXCNT  = 8'h30,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MSG_START,
  input  logic                  BYTE_VALID,
  input  logic [7:0]            RX_BYTE,
  input  logic                  MSG_END,
  input  logic                  MSG_ERR,
  input  logic [2:0]            FRAME_TYPE,
  rx_buf_loader_if.master       bus,
  output logic                  BUSY,
  output logic                  DROP,
  output logic                  ERR
);
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_DET, S_RD_ALERT, S_WR_CNT, S_WR_FT, S_WR_BUF, S_WR_ALERT, S_DONE
  } state_t;

  state_t          state, state_n;
  logic            req_q, req_n;
  logic [TW-1:0]   timer, timer_n;
  logic [CW-1:0]   idx, idx_n;
  logic [7:0]      alert_l, alert_n;
  logic [2:0]      ft_l, ft_n;
  logic            drop_q, drop_n;
  logic            err_q, err_n;

  logic [CW-1:0]   cnt;
  logic            ovf;
  logic [7:0]      rx_mem [MAX_BYTES];

  logic            store_ok;
  logic [CW-1:0]   eff_cnt;
  logic [CW-1:0]   rem;
  logic            eff_ovf;
  logic            reject;

  // A byte arriving with MSG_END is counted before the acceptance decision.
  always_comb begin
    store_ok = BYTE_VALID && (cnt < CW'(MAX_BYTES));
    eff_cnt  = store_ok ? cnt + 1'b1 : cnt;
    eff_ovf  = ovf || (BYTE_VALID && !store_ok);
    rem      = eff_cnt - CW'(2);
    reject   = eff_ovf || (eff_cnt < CW'(2)) || (rem[1:0] != 2'b00) || (FRAME_TYPE > 3'd4);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == S_IDLE) begin
      if (MSG_START || MSG_ERR) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (BYTE_VALID) begin
        if (store_ok) cnt <= cnt + 1'b1;
        else          ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == S_IDLE && !MSG_START && !MSG_ERR && store_ok)
      rx_mem[cnt] <= RX_BYTE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      timer   <= '0;
      idx     <= '0;
      alert_l <= '0;
      ft_l    <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      timer   <= timer_n;
      idx     <= idx_n;
      alert_l <= alert_n;
      ft_l    <= ft_n;
      drop_q  <= drop_n;
      err_q   <= err_n;
    end
  end

  // Each access state raises REQ from a low cycle, so REQ always idles one cycle between accesses.
  always_comb begin
    state_n = state;
    req_n   = req_q;
    timer_n = timer;
    idx_n   = idx;
    alert_n = alert_l;
    ft_n    = ft_l;
    drop_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (MSG_ERR) begin
          drop_n = 1'b1;
        end else if (MSG_END) begin
          if (reject) begin
            drop_n = 1'b1;
          end else begin
            state_n = S_RD_DET;
            ft_n    = FRAME_TYPE;
            idx_n   = '0;
          end
        end
      end
      S_DONE: begin
        drop_n  = MSG_END;
        state_n = S_IDLE;
      end
      default: begin
        drop_n = MSG_END;
        if (!req_q) begin
          req_n   = 1'b1;
          timer_n = '0;
        end else if (bus.ACK_Rx) begin
          req_n = 1'b0;
          case (state)
            S_RD_DET: begin
              if (bus.RD_DATA_Rx[ft_l]) begin
                state_n = S_RD_ALERT;
              end else begin
                drop_n  = 1'b1;
                state_n = S_IDLE;
              end
            end
            S_RD_ALERT: begin
              if (bus.RD_DATA_Rx[2]) begin
                drop_n  = 1'b1;
                state_n = S_IDLE;
              end else begin
                alert_n = bus.RD_DATA_Rx;
                state_n = S_WR_CNT;
              end
            end
            S_WR_CNT:   state_n = S_WR_FT;
            S_WR_FT:    state_n = S_WR_BUF;
            S_WR_BUF: begin
              if (idx == cnt - 1'b1) state_n = S_WR_ALERT;
              else                   idx_n   = idx + 1'b1;
            end
            S_WR_ALERT: state_n = S_DONE;
            default:    state_n = S_IDLE;
          endcase
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.REQ_Rx     = req_q;
    bus.RNW_Rx     = 1'b0;
    bus.ADDR_Rx    = '0;
    bus.WR_DATA_Rx = '0;
    if (req_q) begin
      case (state)
        S_RD_DET: begin
          bus.RNW_Rx  = 1'b1;
          bus.ADDR_Rx = ADDR_RXDET;
        end
        S_RD_ALERT: begin
          bus.RNW_Rx  = 1'b1;
          bus.ADDR_Rx = ADDR_ALERT;
        end
        S_WR_CNT: begin
          bus.ADDR_Rx    = ADDR_RXCNT;
          bus.WR_DATA_Rx = 8'(cnt) + 8'd1;
        end
        S_WR_FT: begin
          bus.ADDR_Rx    = ADDR_RXCNT + 8'd1;
          bus.WR_DATA_Rx = {5'b0, ft_l};
        end
        S_WR_BUF: begin
          bus.ADDR_Rx    = ADDR_RXCNT + 8'd2 + 8'(idx);
          bus.WR_DATA_Rx = rx_mem[idx];
        end
        S_WR_ALERT: begin
          bus.ADDR_Rx    = ADDR_ALERT;
          bus.WR_DATA_Rx = alert_l | 8'h04;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != S_IDLE) && (state != S_DONE);
  assign DROP = drop_q;
  assign ERR  = err_q;
endmodule

// File: tb/tb_rx_buf_loader.sv
// Directed bench for rx_buf_loader: a register-file responder plus a message-level model that predicts
// the register accesses, drops and timeout aborts for each received message.
module tb_rx_buf_loader;
  localparam int unsigned TO      = 64;
  localparam logic [7:0]  A_ALERT = 8'h10;
  localparam logic [7:0]  A_RXDET = 8'h2F;
  localparam logic [7:0]  A_RXCNT = 8'h30;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       MSG_START = 1'b0;
  logic       BYTE_VALID = 1'b0;
  logic [7:0] RX_BYTE = 8'h00;
  logic       MSG_END = 1'b0;
  logic       MSG_ERR = 1'b0;
  logic [2:0] FRAME_TYPE = 3'd0;
  logic       BUSY, DROP, ERR;

  rx_buf_loader_if bus();

  rx_buf_loader #(
    .MAX_BYTES(10), .ADDR_ALERT(A_ALERT), .ADDR_RXDET(A_RXDET), .ADDR_RXCNT(A_RXCNT), .ACK_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MSG_START(MSG_START), .BYTE_VALID(BYTE_VALID), .RX_BYTE(RX_BYTE),
    .MSG_END(MSG_END), .MSG_ERR(MSG_ERR), .FRAME_TYPE(FRAME_TYPE), .bus(bus),
    .BUSY(BUSY), .DROP(DROP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] regs [256];
  int checks = 0, errors = 0;
  int exp_drops = 0, exp_errs = 0, drop_seen = 0, err_seen = 0;
  int acks_left = -1, ack_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-file responder: ACKs a visible request in the same cycle unless acks are withheld.
  initial begin
    bus.ACK_Rx     = 1'b0;
    bus.RD_DATA_Rx = 8'h00;
    foreach (regs[i]) regs[i] = 8'h00;
    forever begin
      @(negedge CLK);
      if (bus.ACK_Rx) begin
        bus.ACK_Rx = 1'b0;
      end else if (bus.REQ_Rx === 1'b1 && acks_left != 0) begin
        bus.ACK_Rx = 1'b1;
        if (bus.RNW_Rx) bus.RD_DATA_Rx = regs[bus.ADDR_Rx];
        else            regs[bus.ADDR_Rx] = bus.WR_DATA_Rx;
        if (acks_left > 0) acks_left--;
        ack_count++;
      end
    end
  end

  // Compare process: every completed access against the model queue, plus handshake rules each cycle.
  logic        prev_req = 1'b0, prev_ack = 1'b0, cur_ack;
  logic [16:0] prev_bus = '0, cur_bus;
  int          run = 0, last_run = 0;
  bit          idle_next = 1'b0;
  txn_t        t_exp, t_got;

  initial begin
    forever begin
      @(negedge CLK);
      #1;
      cur_ack = bus.REQ_Rx && bus.ACK_Rx;
      cur_bus = {bus.RNW_Rx, bus.ADDR_Rx, bus.WR_DATA_Rx};
      if (prev_ack) chk("req_gap_after_ack", bus.REQ_Rx, 0);
      else if (bus.REQ_Rx && prev_req) chk("req_fields_stable", cur_bus, prev_bus);
      if (bus.REQ_Rx) chk("busy_during_req", BUSY, 1);
      if (idle_next) begin
        chk("busy_low_after_alert_write", BUSY, 0);
        idle_next = 1'b0;
      end
      if (cur_ack) begin
        t_got = '{bus.RNW_Rx, bus.ADDR_Rx, (bus.RNW_Rx ? 8'h00 : bus.WR_DATA_Rx)};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got 0x%0h expected none", t_got);
        end else begin
          t_exp = exp_q.pop_front();
          chk("access", t_got, t_exp);
          if (!t_exp.rnw && t_exp.addr == A_ALERT) idle_next = 1'b1;
        end
      end
      if (bus.REQ_Rx && !bus.ACK_Rx) run++;
      else if (!bus.REQ_Rx) begin
        if (run > 0) last_run = run;
        run = 0;
      end else run = 0;
      if (DROP) drop_seen++;
      if (ERR) begin
        err_seen++;
        chk("req_cycles_before_err", last_run, TO);
        chk("req_low_on_err", bus.REQ_Rx, 0);
      end
      prev_req = bus.REQ_Rx;
      prev_ack = cur_ack;
      prev_bus = cur_bus;
    end
  end

  // Message-level model: decide acceptance from the message shape, then list the resulting accesses.
  task automatic model_msg(input logic [7:0] m[$], input int ft, input logic [7:0] rxdet, input logic [7:0] alert);
    int n;
    n = m.size();
    regs[A_RXDET] = rxdet;
    regs[A_ALERT] = alert;
    if (n < 2 || n > 10 || ((n - 2) % 4) != 0 || ft > 4) begin
      exp_drops++;
      return;
    end
    exp_q.push_back('{1'b1, A_RXDET, 8'h00});
    if (!rxdet[ft]) begin
      exp_drops++;
      return;
    end
    exp_q.push_back('{1'b1, A_ALERT, 8'h00});
    if (alert[2]) begin
      exp_drops++;
      return;
    end
    exp_q.push_back('{1'b0, A_RXCNT, 8'(n + 1)});
    exp_q.push_back('{1'b0, A_RXCNT + 8'd1, 8'(ft)});
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, A_RXCNT + 8'd2 + 8'(i), m[i]});
    exp_q.push_back('{1'b0, A_ALERT, alert | 8'h04});
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int ft, input bit with_err);
    @(negedge CLK);
    MSG_START = 1'b1;
    @(negedge CLK);
    MSG_START = 1'b0;
    for (int i = 0; i < m.size(); i++) begin
      BYTE_VALID = 1'b1;
      RX_BYTE    = m[i];
      FRAME_TYPE = 3'(ft);
      MSG_END    = (i == m.size() - 1);
      MSG_ERR    = with_err && (i == m.size() - 1);
      @(negedge CLK);
    end
    BYTE_VALID = 1'b0;
    MSG_END    = 1'b0;
    MSG_ERR    = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3000 && (BUSY || bus.REQ_Rx); k++) @(negedge CLK);
    chk("idle_reached", BUSY, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_pending_accesses"}, exp_q.size(), 0);
    chk({tag, "_drop_count"}, drop_seen, exp_drops);
    chk({tag, "_err_count"}, err_seen, exp_errs);
  endtask

  task automatic run_msg(input string tag, input logic [7:0] m[$], input int ft, input logic [7:0] rxdet,
                         input logic [7:0] alert, input bit poke_end);
    model_msg(m, ft, rxdet, alert);
    send_msg(m, ft, 1'b0);
    if (poke_end) begin
      repeat (3) @(negedge CLK);
      MSG_END = 1'b1;
      exp_drops++;
      @(negedge CLK);
      MSG_END = 1'b0;
    end
    wait_idle();
    end_checks(tag);
  endtask

  logic [7:0] msg[$];
  int         base, req_hi;

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_req", bus.REQ_Rx, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_drop", DROP, 0);
    chk("rst_err", ERR, 0);
    chk("rst_addr", bus.ADDR_Rx, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // 2-byte type 0, with a stray MSG_END while busy
    msg = '{8'hA1, 8'h13};
    run_msg("two_byte", msg, 0, 8'h01, 8'h00, 1'b1);
    chk("two_byte_rxcnt", regs[8'h30], 8'h03);
    chk("two_byte_ft", regs[8'h31], 8'h00);
    chk("two_byte_hdr0", regs[8'h32], 8'hA1);
    chk("two_byte_hdr1", regs[8'h33], 8'h13);
    chk("two_byte_alert", regs[8'h10], 8'h04);

    msg = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};
    run_msg("ten_byte", msg, 1, 8'h02, 8'h81, 1'b0);
    chk("ten_byte_rxcnt", regs[8'h30], 8'h0B);
    chk("ten_byte_ft", regs[8'h31], 8'h01);
    chk("ten_byte_last", regs[8'h3B], 8'hC9);
    chk("ten_byte_alert", regs[8'h10], 8'h85);

    regs[8'h30] = 8'hEE;
    msg = '{8'h11, 8'h22};
    run_msg("alert_pending", msg, 0, 8'h01, 8'h04, 1'b0);
    chk("alert_pending_rxcnt_kept", regs[8'h30], 8'hEE);
    chk("alert_pending_alert_kept", regs[8'h10], 8'h04);

    run_msg("rxdet_off", msg, 2, 8'h01, 8'h00, 1'b0);

    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    run_msg("eleven_bytes", msg, 0, 8'hFF, 8'h00, 1'b0);
    msg = '{8'h01, 8'h02, 8'h03};
    run_msg("three_bytes", msg, 0, 8'hFF, 8'h00, 1'b0);
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_msg("bad_type", msg, 5, 8'hFF, 8'h00, 1'b0);
    chk("drop_pin_after_rejects", drop_seen, 6);

    // MSG_ERR coincident with MSG_END
    msg = '{8'h55, 8'h66};
    exp_drops++;
    send_msg(msg, 0, 1'b1);
    wait_idle();
    end_checks("err_with_end");

    // ACK withheld in WR_BUF
    msg = '{8'h31, 8'h32};
    model_msg(msg, 0, 8'h01, 8'h00);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    exp_errs++;
    acks_left = 4;
    send_msg(msg, 0, 1'b0);
    wait_idle();
    acks_left = -1;
    end_checks("ack_timeout");
    chk("ack_timeout_alert_untouched", regs[8'h10], 8'h00);

    msg = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    run_msg("after_timeout", msg, 4, 8'h10, 8'h00, 1'b0);
    chk("after_timeout_rxcnt", regs[8'h30], 8'h07);
    chk("after_timeout_ft", regs[8'h31], 8'h04);
    chk("after_timeout_last", regs[8'h37], 8'hD5);

    // Reset in the middle of the buffer writes
    msg = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9};
    model_msg(msg, 1, 8'h02, 8'h00);
    base = ack_count;
    send_msg(msg, 1, 1'b0);
    for (int k = 0; k < 500 && ack_count < base + 6; k++) begin
      @(negedge CLK);
      #2;
    end
    chk("reached_wr_buf", (ack_count >= base + 6), 1);
    @(negedge CLK);
    #3 RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("midrst_req", bus.REQ_Rx, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_addr", bus.ADDR_Rx, 0);
    chk("midrst_wdata", bus.WR_DATA_Rx, 0);
    chk("midrst_drop_err", {DROP, ERR}, 0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
    req_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (bus.REQ_Rx) req_hi++;
    end
    chk("no_req_after_reset", req_hi, 0);
    chk("midrst_alert_untouched", regs[8'h10], 8'h00);
    end_checks("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
